// File: rtl/spi_io_pkg.sv
// Shared definitions for the SPI IO controller: register addresses, STATUS and
// CTRL bit positions, the byte-launch FSM state type and the launch timeout.
package spi_io_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_LEVEL  = 2'd3;

  localparam int STAT_TXFULL  = 0;
  localparam int STAT_TXEMPTY = 1;
  localparam int STAT_RXEMPTY = 2;
  localparam int STAT_RXFULL  = 3;
  localparam int STAT_BUSY    = 4;
  localparam int STAT_TXOVF   = 5;
  localparam int STAT_RXOVF   = 6;
  localparam int STAT_RXUNF   = 7;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_DISCARD_RX = 1;
  localparam int CTRL_IRQ_EN     = 2;

  // Cycles o_mosi_dv may stay high waiting for the master to drop ready.
  localparam int LAUNCH_TIMEOUT = 4;
  localparam int TMO_W          = $clog2(LAUNCH_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LAUNCH  = 2'd1,
    S_WAIT_RX = 2'd2,
    S_GAP     = 2'd3
  } fsm_state_e;

  // Occupancy as seen through the 4-bit LEVEL fields.
  function automatic logic [3:0] sat4(input int unsigned n);
    return (n > 15) ? 4'hF : 4'(n);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// 8-bit synchronous FIFO with occupancy count.
// A pop and a push in the same cycle both take effect, even when full: the
// pop frees the slot the push then uses, so the count is unchanged.
// Ports: clk_i, rst_ni (async active-low), push_i/wdata_i, pop_i, rdata_o
// (head entry, combinational), count_o, full_o, empty_o.
module sync_fifo #(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [7:0]    wdata_i,
  input  logic          pop_i,
  output logic [7:0]    rdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits wide and wrap on their own.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; the count marks which entries
  // are valid, and leaving the array out of reset lets it map onto RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/spi_io_ctrl.sv
// IO-mapped byte-stream front end for the SPI byte master. The CPU fills a TX
// FIFO through DATA writes; an FSM launches one byte at a time on the master's
// dv/ready handshake and stores each returned byte in an RX FIFO for DATA reads.
// Ports: i_clk, i_rst_n (async active-low); IO bus i_wr, i_rd, i_addr,
// i_wr_data, o_rd_data (registered); master side o_mosi_byte, o_mosi_dv,
// i_mosi_ready, i_miso_dv, i_miso_byte; o_irq (registered level).
module spi_io_ctrl
  import spi_io_pkg::*;
#(
  parameter  int FIFO_DEPTH = 8,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr,
  input  logic       i_rd,
  input  logic [1:0] i_addr,
  input  logic [7:0] i_wr_data,
  output logic [7:0] o_rd_data,
  output logic [7:0] o_mosi_byte,
  output logic       o_mosi_dv,
  input  logic       i_mosi_ready,
  input  logic       i_miso_dv,
  input  logic [7:0] i_miso_byte,
  output logic       o_irq
);

  fsm_state_e       state_q;
  logic [7:0]       mosi_byte_q;
  logic             mosi_dv_q;
  logic [TMO_W-1:0] tmo_cnt_q;

  logic en_q, discard_q, irq_en_q;
  logic txovf_q, rxovf_q, rxunf_q;
  logic txovf_d, rxovf_d, rxunf_d;
  logic irq_q, irq_d;
  logic [7:0] rd_data_q, rd_mux;

  logic [7:0]    tx_rdata, rx_rdata;
  logic [CW-1:0] tx_count, rx_count;
  logic          tx_full, tx_empty, rx_full, rx_empty;

  // A read colliding with a write is dropped; the write goes ahead.
  logic rd_acc, wr_data, rd_data;
  assign rd_acc  = i_rd & ~i_wr;
  assign wr_data = i_wr & (i_addr == ADDR_DATA);
  assign rd_data = rd_acc & (i_addr == ADDR_DATA);

  logic tx_pop, rx_push, rx_pop, busy, launch_timeout;
  assign busy           = (state_q != S_IDLE);
  assign tx_pop         = (state_q == S_IDLE) & en_q & ~tx_empty & i_mosi_ready;
  assign rx_push        = (state_q == S_WAIT_RX) & i_miso_dv & ~discard_q;
  assign rx_pop         = rd_data & ~rx_empty;
  assign launch_timeout = (state_q == S_LAUNCH) & i_mosi_ready &
                          (tmo_cnt_q == TMO_W'(LAUNCH_TIMEOUT - 1));

  sync_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(i_clk), .rst_ni(i_rst_n),
    .push_i(wr_data), .wdata_i(i_wr_data), .pop_i(tx_pop), .rdata_o(tx_rdata),
    .count_o(tx_count), .full_o(tx_full), .empty_o(tx_empty)
  );

  sync_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(i_clk), .rst_ni(i_rst_n),
    .push_i(rx_push), .wdata_i(i_miso_byte), .pop_i(rx_pop), .rdata_o(rx_rdata),
    .count_o(rx_count), .full_o(rx_full), .empty_o(rx_empty)
  );

  logic [7:0] status;
  assign status = {rxunf_q, rxovf_q, txovf_q, busy, rx_full, rx_empty, tx_empty, tx_full};

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    txovf_d = txovf_q;
    rxovf_d = rxovf_q;
    rxunf_d = rxunf_q;
    if (i_wr && i_addr == ADDR_STATUS) begin
      txovf_d = txovf_q & ~i_wr_data[STAT_TXOVF];
      rxovf_d = rxovf_q & ~i_wr_data[STAT_RXOVF];
      rxunf_d = rxunf_q & ~i_wr_data[STAT_RXUNF];
    end
    // A new error event wins over a clear in the same cycle.
    if ((wr_data && tx_full && !tx_pop) || launch_timeout) txovf_d = 1'b1;
    if (rx_push && rx_full && !rx_pop)                     rxovf_d = 1'b1;
    if (rd_data && rx_empty)                               rxunf_d = 1'b1;

    rd_mux = 8'h00;
    case (i_addr)
      ADDR_DATA:   rd_mux = rx_empty ? 8'h00 : rx_rdata;
      ADDR_STATUS: rd_mux = status;
      ADDR_CTRL:   rd_mux = {5'b0, irq_en_q, discard_q, en_q};
      ADDR_LEVEL:  rd_mux = {sat4(32'(rx_count)), sat4(32'(tx_count))};
      default:     rd_mux = 8'h00;
    endcase

    irq_d = irq_en_q & (~rx_empty | (tx_empty & ~busy) | txovf_q | rxovf_q | rxunf_q);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_q      <= 1'b0;
      discard_q <= 1'b0;
      irq_en_q  <= 1'b0;
      txovf_q   <= 1'b0;
      rxovf_q   <= 1'b0;
      rxunf_q   <= 1'b0;
      irq_q     <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      if (i_wr && i_addr == ADDR_CTRL) begin
        en_q      <= i_wr_data[CTRL_EN];
        discard_q <= i_wr_data[CTRL_DISCARD_RX];
        irq_en_q  <= i_wr_data[CTRL_IRQ_EN];
      end
      txovf_q <= txovf_d;
      rxovf_q <= rxovf_d;
      rxunf_q <= rxunf_d;
      irq_q   <= irq_d;
      if (rd_acc) rd_data_q <= rd_mux;
    end
  end

  // Byte-launch FSM. EN is only consulted in IDLE, so clearing it lets an
  // in-flight byte finish. WAIT_RX and GAP keep dv low for at least two
  // cycles between bytes so the master always sees a fresh rising edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      mosi_byte_q <= 8'h00;
      mosi_dv_q   <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (tx_pop) begin
            mosi_byte_q <= tx_rdata;
            mosi_dv_q   <= 1'b1;
            tmo_cnt_q   <= '0;
            state_q     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (!i_mosi_ready) begin
            mosi_dv_q <= 1'b0;
            state_q   <= S_WAIT_RX;
          end else if (launch_timeout) begin
            // Master never accepted the byte: it is lost (flagged as TXOVF).
            mosi_dv_q <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        S_WAIT_RX: if (i_miso_dv)    state_q <= S_GAP;
        S_GAP:     if (i_mosi_ready) state_q <= S_IDLE;
        default:                     state_q <= S_IDLE;
      endcase
    end
  end

  assign o_rd_data   = rd_data_q;
  assign o_mosi_byte = mosi_byte_q;
  assign o_mosi_dv   = mosi_dv_q;
  assign o_irq       = irq_q;

endmodule

// File: tb/tb_spi_io_ctrl.sv
// Self-checking bench for spi_io_ctrl. A behavioural SPI master answers every
// launched byte with its complement; expected values come from queues of
// what the CPU wrote and from the register map's rules.
module tb_spi_io_ctrl;
  import spi_io_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_wr = 1'b0, i_rd = 1'b0;
  logic [1:0] i_addr = 2'd0;
  logic [7:0] i_wr_data = 8'h00;
  logic [7:0] o_rd_data, o_mosi_byte;
  logic       o_mosi_dv, o_irq;
  logic       i_mosi_ready = 1'b1;
  logic       i_miso_dv = 1'b0;
  logic [7:0] i_miso_byte = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;

  logic       master_on = 1'b0;
  logic [7:0] sent_q[$];     // bytes seen on dv rising edges by the master
  logic [7:0] exp_tx[$];     // bytes the CPU expects to go out, in order
  logic [7:0] pending_byte;  // byte left in TX for the timeout scenario

  spi_io_ctrl #(.FIFO_DEPTH(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr(i_wr), .i_rd(i_rd), .i_addr(i_addr),
    .i_wr_data(i_wr_data), .o_rd_data(o_rd_data), .o_mosi_byte(o_mosi_byte),
    .o_mosi_dv(o_mosi_dv), .i_mosi_ready(i_mosi_ready), .i_miso_dv(i_miso_dv),
    .i_miso_byte(i_miso_byte), .o_irq(o_irq)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural master: accept on dv while ready, drop ready, return ~byte.
  initial begin : master_model
    logic [7:0] b;
    forever begin
      @(posedge i_clk); #1;
      if (master_on && o_mosi_dv && i_mosi_ready) begin
        b = o_mosi_byte;
        sent_q.push_back(b);
        i_mosi_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_miso_byte = ~b;
        i_miso_dv   = 1'b1;
        @(posedge i_clk); #1;
        i_miso_dv    = 1'b0;
        i_mosi_ready = 1'b1;
      end
    end
  end

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    i_wr = 1'b1; i_addr = a; i_wr_data = d;
    @(posedge i_clk); #1;
    i_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    i_rd = 1'b1; i_addr = a;
    @(posedge i_clk); #1;
    i_rd = 1'b0;
    d = o_rd_data;
  endtask

  task automatic wait_sent(input int n);
    int k = 0;
    while (sent_q.size() < n && k < 600) begin @(posedge i_clk); #1; k++; end
    repeat (12) @(posedge i_clk);
    #1;
    n_checks++;
    if (sent_q.size() != n) begin
      n_fail++;
      $display("FAIL wait_sent: master saw %0d bytes, expected %0d", sent_q.size(), n);
    end
  endtask

  task automatic wait_dv_high(input int budget);
    int k = 0;
    while (!o_mosi_dv && k < budget) begin @(posedge i_clk); #1; k++; end
    n_checks++;
    if (!o_mosi_dv) begin
      n_fail++;
      $display("FAIL dv_wait: o_mosi_dv=%0b after %0d cycles, expected 1", o_mosi_dv, budget);
    end
  endtask

  task automatic expect8(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    #2;
    n_checks++;
    if ({o_rd_data, o_mosi_byte, o_mosi_dv, o_irq} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd=%02h byte=%02h dv=%0b irq=%0b expected all 0",
               o_rd_data, o_mosi_byte, o_mosi_dv, o_irq);
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    cpu_read(ADDR_STATUS, rd); expect8("reset_status", rd, 8'h06);
    cpu_read(ADDR_CTRL, rd);   expect8("reset_ctrl", rd, 8'h00);
    cpu_read(ADDR_LEVEL, rd);  expect8("reset_level", rd, 8'h00);
  endtask

  // Send the bytes in exp_tx with EN set, then check order and echoed RX data.
  task automatic run_stream(input string tag);
    logic [7:0] rd;
    sent_q.delete();
    master_on = 1'b1;
    cpu_write(ADDR_CTRL, 8'h01);
    foreach (exp_tx[i]) cpu_write(ADDR_DATA, exp_tx[i]);
    wait_sent(exp_tx.size());
    foreach (exp_tx[i]) begin
      n_checks++;
      if (sent_q[i] !== exp_tx[i]) begin
        n_fail++;
        $display("FAIL %s_mosi[%0d]: got %02h expected %02h", tag, i, sent_q[i], exp_tx[i]);
      end
    end
    cpu_read(ADDR_STATUS, rd);
    expect8({tag, "_status_before_drain"}, rd, (exp_tx.size() == 8) ? 8'h0A : 8'h02);
    foreach (exp_tx[i]) begin
      cpu_read(ADDR_DATA, rd);
      expect8({tag, "_rx"}, rd, ~exp_tx[i]);
    end
    cpu_read(ADDR_STATUS, rd); expect8({tag, "_status_end"}, rd, 8'h06);
    master_on = 1'b0;
  endtask

  task automatic test_basic_transfer();
    exp_tx.delete();
    exp_tx.push_back(8'hA5);
    exp_tx.push_back(8'h3C);
    run_stream("basic");
  endtask

  task automatic test_back_to_back();
    int n;
    exp_tx.delete();
    n = $urandom_range(3, 8);
    for (int i = 0; i < n; i++) exp_tx.push_back(8'($urandom));
    run_stream("b2b");
  endtask

  task automatic test_tx_overflow();
    logic [7:0] rd, b;
    exp_tx.delete();
    cpu_write(ADDR_CTRL, 8'h00);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      if (i < 8) exp_tx.push_back(b);
      cpu_write(ADDR_DATA, b);
    end
    cpu_read(ADDR_LEVEL, rd);  expect8("txovf_level", rd, 8'h08);
    cpu_read(ADDR_STATUS, rd); expect8("txovf_status", rd, 8'h25);
    cpu_write(ADDR_STATUS, 8'h20);
    cpu_read(ADDR_STATUS, rd); expect8("txovf_cleared", rd, 8'h05);
  endtask

  // TX is full; the DATA write lands in the same cycle as the first launch.
  task automatic test_simultaneous_push_pop();
    logic [7:0] rd, b;
    sent_q.delete();
    i_mosi_ready = 1'b1;
    master_on = 1'b1;
    b = 8'($urandom);
    exp_tx.push_back(b);
    cpu_write(ADDR_CTRL, 8'h03);
    cpu_write(ADDR_DATA, b);
    wait_sent(9);
    foreach (exp_tx[i]) begin
      n_checks++;
      if (sent_q[i] !== exp_tx[i]) begin
        n_fail++;
        $display("FAIL simul_mosi[%0d]: got %02h expected %02h", i, sent_q[i], exp_tx[i]);
      end
    end
    cpu_read(ADDR_STATUS, rd); expect8("simul_status", rd, 8'h06);
    cpu_read(ADDR_LEVEL, rd);  expect8("simul_level", rd, 8'h00);
    master_on = 1'b0;
  endtask

  task automatic test_rx_overflow();
    logic [7:0] rd;
    sent_q.delete();
    exp_tx.delete();
    master_on = 1'b1;
    cpu_write(ADDR_CTRL, 8'h01);
    for (int i = 0; i < 9; i++) exp_tx.push_back(8'($urandom));
    for (int i = 0; i < 8; i++) cpu_write(ADDR_DATA, exp_tx[i]);
    wait_sent(8);
    cpu_read(ADDR_LEVEL, rd);  expect8("rxfull_level", rd, 8'h80);
    cpu_read(ADDR_STATUS, rd); expect8("rxfull_status", rd, 8'h0A);
    cpu_write(ADDR_DATA, exp_tx[8]);
    wait_sent(9);
    cpu_read(ADDR_STATUS, rd); expect8("rxovf_status", rd, 8'h4A);
    cpu_read(ADDR_LEVEL, rd);  expect8("rxovf_level", rd, 8'h80);
    cpu_write(ADDR_CTRL, 8'h03);
    for (int i = 0; i < 3; i++) cpu_write(ADDR_DATA, 8'($urandom));
    wait_sent(12);
    cpu_read(ADDR_LEVEL, rd);  expect8("discard_level", rd, 8'h80);
    for (int i = 0; i < 8; i++) begin
      cpu_read(ADDR_DATA, rd);
      expect8("rxovf_drain", rd, ~exp_tx[i]);
    end
    cpu_read(ADDR_STATUS, rd); expect8("rxovf_status_end", rd, 8'h46);
    cpu_write(ADDR_STATUS, 8'hE0);
    cpu_write(ADDR_CTRL, 8'h00);
    master_on = 1'b0;
  endtask

  task automatic test_rx_underflow();
    logic [7:0] rd;
    cpu_read(ADDR_DATA, rd);   expect8("rxunf_data", rd, 8'h00);
    cpu_read(ADDR_STATUS, rd); expect8("rxunf_status", rd, 8'h86);
    cpu_write(ADDR_STATUS, 8'hE0);
    // Colliding read and write: the write is taken, the read is ignored.
    pending_byte = 8'($urandom_range(1, 255));
    i_wr = 1'b1; i_rd = 1'b1; i_addr = ADDR_DATA; i_wr_data = pending_byte;
    @(posedge i_clk); #1;
    i_wr = 1'b0; i_rd = 1'b0;
    expect8("collide_rd_held", o_rd_data, 8'h86);
    cpu_read(ADDR_LEVEL, rd);  expect8("collide_level", rd, 8'h01);
    cpu_read(ADDR_STATUS, rd); expect8("collide_status", rd, 8'h04);
  endtask

  task automatic test_launch_timeout();
    logic [7:0] rd;
    int high = 0;
    master_on = 1'b0;
    i_mosi_ready = 1'b1;
    cpu_write(ADDR_CTRL, 8'h01);
    for (int i = 0; i < 20; i++) begin
      @(posedge i_clk); #1;
      if (o_mosi_dv) begin
        high++;
        expect8("timeout_byte", o_mosi_byte, pending_byte);
      end
    end
    n_checks++;
    if (high != LAUNCH_TIMEOUT) begin
      n_fail++;
      $display("FAIL timeout_dv_cycles: got %0d expected %0d", high, LAUNCH_TIMEOUT);
    end
    cpu_read(ADDR_STATUS, rd); expect8("timeout_status", rd, 8'h26);
    cpu_write(ADDR_STATUS, 8'hE0);
    cpu_write(ADDR_CTRL, 8'h00);
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] rd, b1, b2, b3;
    b1 = 8'($urandom_range(1, 255));
    b2 = 8'($urandom_range(1, 255));
    b3 = 8'($urandom_range(1, 255));
    master_on = 1'b0;
    i_mosi_ready = 1'b1;
    cpu_write(ADDR_CTRL, 8'h05);
    cpu_write(ADDR_DATA, b1);
    wait_dv_high(10);
    i_mosi_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_miso_byte = ~b1; i_miso_dv = 1'b1;
    @(posedge i_clk); #1;
    i_miso_dv = 1'b0; i_mosi_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    cpu_write(ADDR_DATA, b2);
    cpu_write(ADDR_DATA, b3);
    wait_dv_high(10);
    i_mosi_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    cpu_read(ADDR_LEVEL, rd);
    expect8("mid_level", rd, 8'h11);
    expect8("mid_byte_held", o_mosi_byte, b2);
    n_checks++;
    if (o_irq !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_irq: got %0b expected 1", o_irq);
    end
    #3 i_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_rd_data, o_mosi_byte, o_mosi_dv, o_irq} !== 18'h0) begin
      n_fail++;
      $display("FAIL async_reset: got rd=%02h byte=%02h dv=%0b irq=%0b expected all 0",
               o_rd_data, o_mosi_byte, o_mosi_dv, o_irq);
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    i_mosi_ready = 1'b1;
    cpu_read(ADDR_LEVEL, rd);  expect8("post_reset_level", rd, 8'h00);
    cpu_read(ADDR_STATUS, rd); expect8("post_reset_status", rd, 8'h06);
  endtask

  task automatic test_irq();
    logic [7:0] rd, b, b2, echo;
    b    = 8'($urandom);
    b2   = 8'($urandom);
    echo = 8'($urandom);
    master_on = 1'b0;
    i_mosi_ready = 1'b1;
    cpu_write(ADDR_DATA, b);
    cpu_write(ADDR_CTRL, 8'h05);
    wait_dv_high(10);
    i_mosi_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    n_checks++;
    if (o_irq !== 1'b0) begin n_fail++; $display("FAIL irq_busy: got %0b expected 0", o_irq); end
    i_miso_byte = echo; i_miso_dv = 1'b1;
    @(posedge i_clk); #1;   // RX push happens on this edge
    i_miso_dv = 1'b0;
    n_checks++;
    if (o_irq !== 1'b0) begin n_fail++; $display("FAIL irq_push_edge: got %0b expected 0", o_irq); end
    @(posedge i_clk); #1;
    n_checks++;
    if (o_irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %0b expected 1", o_irq); end
    i_mosi_ready = 1'b1;
    cpu_write(ADDR_CTRL, 8'h04);
    cpu_write(ADDR_DATA, b2);
    repeat (3) @(posedge i_clk);
    #1;
    n_checks++;
    if (o_irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold: got %0b expected 1", o_irq); end
    cpu_read(ADDR_DATA, rd);  // RX pop happens on this edge
    expect8("irq_rx_data", rd, echo);
    n_checks++;
    if (o_irq !== 1'b1) begin n_fail++; $display("FAIL irq_pop_edge: got %0b expected 1", o_irq); end
    @(posedge i_clk); #1;
    n_checks++;
    if (o_irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall: got %0b expected 0", o_irq); end
  endtask

  initial begin
    test_reset();
    test_basic_transfer();
    test_back_to_back();
    test_tx_overflow();
    test_simultaneous_push_pop();
    test_rx_overflow();
    test_rx_underflow();
    test_launch_timeout();
    test_reset_mid_byte();
    test_irq();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
